// File: rtl/prog_sequencer.sv
// Program-address sequencer feeding the control-word ROM: run / halt / single-step, DONE on LAST_ADDR or ROM end marker.
// Optional breakpoint support is compiled in with `define SEQ_BREAKPOINT_EN.
module prog_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 12,
  parameter int RUN_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 step,
  input  logic [3:0]           rom_reg_addr,
  input  logic [2:0]           rom_alu_code,
`ifdef SEQ_BREAKPOINT_EN
  input  logic [ADDR_W-1:0]    bp_addr,
  input  logic                 bp_en,
`endif
  output logic [ADDR_W-1:0]    addr,
  output logic                 instr_valid,
  output logic                 running,
  output logic                 done,
  output logic [RUN_CNT_W-1:0] run_cnt,
  output logic                 bp_hit
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t                 r_state, w_nxt;
  logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
  logic [RUN_CNT_W-1:0]   r_run_cnt;
  logic                   r_running, r_done;
  logic                   w_end, w_last, w_iv, w_bp;

  assign w_end  = (rom_reg_addr == 4'hF) && (rom_alu_code == 3'h7);
  assign w_last = (r_addr == ADDR_W'(LAST_ADDR));

`ifdef SEQ_BREAKPOINT_EN
  logic r_skip, r_bp_hit;
  // r_skip lets the resumed instruction at bp_addr run once without re-trapping.
  assign w_bp = (r_state == S_RUN) && bp_en && (r_addr == bp_addr) && !r_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip   <= 1'b0;
      r_bp_hit <= 1'b0;
    end else begin
      r_bp_hit <= w_bp;
      if (w_bp)
        r_skip <= 1'b1;
      else if ((w_addr_nxt != r_addr) || (r_state == S_IDLE) || (r_state == S_DONE))
        r_skip <= 1'b0;
    end
  end
  assign bp_hit = r_bp_hit;
`else
  assign w_bp   = 1'b0;
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    w_nxt      = r_state;
    w_addr_nxt = r_addr;
    w_iv       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nxt      = S_RUN;
          w_addr_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_bp) begin
          w_nxt = S_PAUSE;
        end else begin
          w_iv = !w_end;
          if (w_end || w_last) begin
            w_nxt = S_DONE;
          end else begin
            w_addr_nxt = r_addr + 1'b1;
            if (halt_req) w_nxt = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        // A step in the same cycle as halt release executes first; RUN follows.
        if (step) begin
          w_iv = !w_end;
          if (w_end || w_last) begin
            w_nxt = S_DONE;
          end else begin
            w_addr_nxt = r_addr + 1'b1;
            w_nxt      = halt_req ? S_PAUSE : S_RUN;
          end
        end else if (!halt_req) begin
          w_nxt = S_RUN;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_nxt;
      r_addr    <= w_addr_nxt;
      r_running <= (w_nxt == S_RUN);
      r_done    <= (w_nxt == S_DONE);
      if ((w_nxt == S_DONE) && (r_state != S_DONE) && (r_run_cnt != '1))
        r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  assign addr        = r_addr;
  assign instr_valid = w_iv;
  assign running     = r_running;
  assign done        = r_done;
  assign run_cnt     = r_run_cnt;

endmodule
